// File: rtl/riscv_run_ctrl.sv
// Run controller and instruction-memory loader behind the AXI4-Lite register slave.
// Turns level-type software controls into write strobes, a core reset/run handshake and counters.
module riscv_run_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              w_mem_reset_n,
  input  logic              w_run_pc_in,
  input  logic [31:0]       w_slv_reg1,
  input  logic [31:0]       w_slv_reg2,
  input  logic [31:0]       w_slv_reg3,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              core_run,
  output logic [1:0]        state,
  output logic              err,
  output logic [15:0]       wr_count,
  output logic [31:0]       cycle_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  logic              tog_prev_q;
  logic              run_prev_q;
  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic              core_rst_n_q;
  logic              core_run_q;

  logic              tog_evt;
  logic              run_rise;
  logic              run_fall;
  logic              addr_ok;
  logic              accept;
  logic              limit_hit;
  logic [15:0]       limit;
  logic [14:0]       unused_reg3;

  assign unused_reg3 = w_slv_reg3[15:1];

  always_comb begin
    tog_evt   = w_slv_reg3[0] ^ tog_prev_q;
    run_rise  = w_run_pc_in & ~run_prev_q;
    run_fall  = ~w_run_pc_in & run_prev_q;
    limit     = w_slv_reg3[31:16];
    addr_ok   = (w_slv_reg1[1:0] == 2'b00) && (w_slv_reg1[31:ADDR_W+2] == '0);
    accept    = tog_evt && (state_q == StIdle) && w_mem_reset_n && addr_ok;
    // Compared one ahead so the run window closes after exactly LIMIT active cycles.
    limit_hit = (limit != 16'd0) &&
                (({1'b0, cycle_cnt_q} + 33'd1) == {17'd0, limit});
  end

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    wr_count_d  = wr_count_q;
    cycle_cnt_d = cycle_cnt_q;

    if (accept) begin
      we_d       = 1'b1;
      addr_d     = w_slv_reg1[ADDR_W+1:2];
      wdata_d    = w_slv_reg2;
      wr_count_d = wr_count_q + 16'd1;
    end else if (tog_evt) begin
      err_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        cycle_cnt_d = '0;
        if (run_rise) state_d = StArm;
      end
      StArm: begin
        cycle_cnt_d = '0;
        state_d     = StRun;
      end
      StRun: begin
        if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (run_fall || limit_hit) state_d = StHalt;
      end
      StHalt: begin
        // Resume keeps the core out of reset; only the counter restarts.
        if (run_rise) begin
          cycle_cnt_d = '0;
          state_d     = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!w_mem_reset_n) begin
      state_d     = StIdle;
      we_d        = 1'b0;
      err_d       = 1'b0;
      wr_count_d  = '0;
      cycle_cnt_d = '0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      tog_prev_q   <= 1'b0;
      run_prev_q   <= 1'b0;
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      wr_count_q   <= '0;
      cycle_cnt_q  <= '0;
      core_rst_n_q <= 1'b0;
      core_run_q   <= 1'b0;
    end else begin
      tog_prev_q   <= w_slv_reg3[0];
      run_prev_q   <= w_run_pc_in;
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      wr_count_q   <= wr_count_d;
      cycle_cnt_q  <= cycle_cnt_d;
      core_rst_n_q <= (state_d != StIdle);
      core_run_q   <= (state_d == StRun);
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign core_run   = core_run_q;
  assign state      = state_q;
  assign err        = err_q;
  assign wr_count   = wr_count_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: vector table, directed run/limit sequences and random stimulus
// compared cycle by cycle against a behavioural model of the run controller.
module tb_riscv_run_ctrl;

  logic        clk = 1'b0;
  logic        aresetn, mrst, run;
  logic [31:0] r1, r2, r3;
  logic        we, core_rst_n, core_run, err;
  logic [9:0]  addr;
  logic [31:0] wdata, cycle_cnt;
  logic [1:0]  state;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;
  logic tog = 1'b0;

  // Model of the controller: mode uses the published state numbering.
  int          m_mode;
  logic        m_rstn, m_run, m_we, m_err, m_tprev, m_rprev;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_cyc;
  logic [15:0] m_wr;

  always #5 clk = ~clk;

  riscv_run_ctrl #(.ADDR_W(10)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(aresetn),
    .w_mem_reset_n  (mrst),
    .w_run_pc_in    (run),
    .w_slv_reg1     (r1),
    .w_slv_reg2     (r2),
    .w_slv_reg3     (r3),
    .imem_we        (we),
    .imem_addr      (addr),
    .imem_wdata     (wdata),
    .core_rst_n     (core_rst_n),
    .core_run       (core_run),
    .state          (state),
    .err            (err),
    .wr_count       (wr_count),
    .cycle_cnt      (cycle_cnt)
  );

  typedef struct {
    logic        rstn;
    logic        mrst;
    logic        run;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [1:0]  e_state;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    logic        e_err;
    logic [15:0] e_wr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic        toggle, rise, fall;
    logic [15:0] lim;
    if (!aresetn) begin
      m_mode = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_err = 0;
      m_wr = '0; m_cyc = '0; m_tprev = 0; m_rprev = 0;
    end else begin
      toggle = (r3[0] != m_tprev);
      rise   = run && !m_rprev;
      fall   = !run && m_rprev;
      lim    = r3[31:16];
      m_we   = 0;
      if (!mrst) begin
        m_mode = 0; m_err = 0; m_wr = '0; m_cyc = '0;
      end else begin
        if (toggle) begin
          if (m_mode == 0 && r1 % 4 == 0 && r1 < 32'd4096) begin
            m_we = 1; m_addr = 10'(r1 / 4); m_wdata = r2; m_wr = m_wr + 16'd1;
          end else begin
            m_err = 1;
          end
        end
        if (m_mode == 0) begin
          if (rise) m_mode = 1;
        end else if (m_mode == 1) begin
          m_cyc = '0; m_mode = 2;
        end else if (m_mode == 2) begin
          if (m_cyc < 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
          if (fall || (lim != 0 && m_cyc == {16'd0, lim})) m_mode = 3;
        end else if (rise) begin
          m_cyc = '0; m_mode = 2;
        end
      end
      m_tprev = r3[0];
      m_rprev = run;
    end
    m_rstn = (m_mode != 0);
    m_run  = (m_mode == 2);
  endtask

  task automatic check_model();
    chk("model state", {30'd0, state}, m_mode[31:0]);
    chk("model core_rst_n", {31'd0, core_rst_n}, {31'd0, m_rstn});
    chk("model core_run", {31'd0, core_run}, {31'd0, m_run});
    chk("model imem_we", {31'd0, we}, {31'd0, m_we});
    chk("model imem_addr", {22'd0, addr}, {22'd0, m_addr});
    chk("model imem_wdata", wdata, m_wdata);
    chk("model err", {31'd0, err}, {31'd0, m_err});
    chk("model wr_count", {16'd0, wr_count}, {16'd0, m_wr});
    chk("model cycle_cnt", cycle_cnt, m_cyc);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_r3(input logic [15:0] lim);
    r3 = {lim, 15'd0, tog};
  endtask

  task automatic to_idle();
    mrst = 1'b0; step();
    mrst = 1'b1; run = 1'b0; step();
  endtask

  initial begin
    m_mode = 0; m_rstn = 0; m_run = 0; m_we = 0; m_err = 0; m_tprev = 0; m_rprev = 0;
    m_addr = '0; m_wdata = '0; m_cyc = '0; m_wr = '0;

    vecs[0] = '{0, 1, 0, 32'h0,    32'h0,        32'h0, 0, 0, 10'h000, 32'h0,        0, 16'd0};
    vecs[1] = '{1, 1, 0, 32'h8,    32'hDEADBEEF, 32'h0, 0, 0, 10'h000, 32'h0,        0, 16'd0};
    vecs[2] = '{1, 1, 0, 32'h8,    32'hDEADBEEF, 32'h1, 0, 1, 10'h002, 32'hDEADBEEF, 0, 16'd1};
    vecs[3] = '{1, 1, 0, 32'h8,    32'hDEADBEEF, 32'h1, 0, 0, 10'h002, 32'hDEADBEEF, 0, 16'd1};
    vecs[4] = '{1, 1, 0, 32'h6,    32'h11111111, 32'h0, 0, 0, 10'h002, 32'hDEADBEEF, 1, 16'd1};
    vecs[5] = '{1, 1, 0, 32'h6,    32'h11111111, 32'h0, 0, 0, 10'h002, 32'hDEADBEEF, 1, 16'd1};
    vecs[6] = '{1, 0, 0, 32'h6,    32'h11111111, 32'h0, 0, 0, 10'h002, 32'hDEADBEEF, 0, 16'd0};
    vecs[7] = '{1, 1, 0, 32'hFFC,  32'h12345678, 32'h1, 0, 1, 10'h3FF, 32'h12345678, 0, 16'd1};
    vecs[8] = '{1, 1, 0, 32'h1000, 32'h55555555, 32'h0, 0, 0, 10'h3FF, 32'h12345678, 1, 16'd1};
    vecs[9] = '{1, 0, 0, 32'h20,   32'h66666666, 32'h1, 0, 0, 10'h3FF, 32'h12345678, 0, 16'd0};

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      aresetn = 1'b0; mrst = 1'($urandom); run = 1'($urandom);
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      step();
    end
    chk("reset state", {30'd0, state}, 32'd0);
    chk("reset outputs", {we, core_rst_n, core_run, err, 28'd0}, 32'd0);
    chk("reset counters", cycle_cnt | {16'd0, wr_count} | {22'd0, addr} | wdata, 32'd0);

    foreach (vecs[i]) begin
      aresetn = vecs[i].rstn; mrst = vecs[i].mrst; run = vecs[i].run;
      r1 = vecs[i].r1; r2 = vecs[i].r2; r3 = vecs[i].r3;
      step();
      chk($sformatf("vec%0d state", i), {30'd0, state}, {30'd0, vecs[i].e_state});
      chk($sformatf("vec%0d imem_we", i), {31'd0, we}, {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d imem_addr", i), {22'd0, addr}, {22'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d imem_wdata", i), wdata, vecs[i].e_data);
      chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
      chk($sformatf("vec%0d wr_count", i), {16'd0, wr_count}, {16'd0, vecs[i].e_wr});
    end
    tog = r3[0];

    // Unlimited run, halt after 100 active cycles, then resume.
    to_idle();
    set_r3(16'd0);
    run = 1'b1; step();
    chk("arm state", {30'd0, state}, 32'd1);
    chk("arm rst/run", {30'd0, core_rst_n, core_run}, 32'd2);
    step();
    chk("run state", {30'd0, state}, 32'd2);
    chk("run core_run", {31'd0, core_run}, 32'd1);
    for (int i = 0; i < 99; i++) step();
    run = 1'b0; step();
    chk("halt state", {30'd0, state}, 32'd3);
    chk("halt cycle_cnt", cycle_cnt, 32'd100);
    chk("halt rst/run", {30'd0, core_rst_n, core_run}, 32'd2);
    run = 1'b1; step();
    chk("resume state", {30'd0, state}, 32'd2);
    chk("resume cycle_cnt", cycle_cnt, 32'd0);

    // Cycle-limited run of 5.
    to_idle();
    set_r3(16'd5);
    run = 1'b1; step(); step();
    for (int i = 0; i < 4; i++) step();
    chk("limit still running", {30'd0, state}, 32'd2);
    step();
    chk("limit halt state", {30'd0, state}, 32'd3);
    chk("limit cycle_cnt", cycle_cnt, 32'd5);
    for (int i = 0; i < 3; i++) step();
    chk("limit stays halted", {29'd0, state, core_run}, 32'd6);

    // Toggle during RUN, then memory reset during RUN.
    set_r3(16'd0);
    run = 1'b0; step();
    run = 1'b1; step();
    chk("rerun state", {30'd0, state}, 32'd2);
    tog = ~tog; set_r3(16'd0); r1 = 32'h40; step();
    chk("run toggle no write", {31'd0, we}, 32'd0);
    chk("run toggle err", {31'd0, err}, 32'd1);
    chk("run toggle continues", {30'd0, state}, 32'd2);
    mrst = 1'b0; step();
    chk("mrst in run state", {30'd0, state}, 32'd0);
    chk("mrst in run core_rst_n", {31'd0, core_rst_n}, 32'd0);

    // Toggle and run rise on the same edge in IDLE.
    mrst = 1'b1; run = 1'b0; step();
    r1 = 32'h10; r2 = 32'hCAFEF00D; tog = ~tog; set_r3(16'd0); run = 1'b1; step();
    chk("simul write", {31'd0, we}, 32'd1);
    chk("simul addr", {22'd0, addr}, 32'd4);
    chk("simul state", {30'd0, state}, 32'd1);
    step();
    chk("simul then run", {30'd0, state}, 32'd2);

    // Reset mid-run with run held high.
    aresetn = 1'b0; step();
    chk("aresetn mid-run", {29'd0, state, core_rst_n}, 32'd0);
    aresetn = 1'b1; tog = r3[0]; step();
    chk("rise after release", {30'd0, state}, 32'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      aresetn = ($urandom_range(0, 63) != 0);
      mrst    = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      sel = int'($urandom_range(0, 7));
      if (sel < 5) r1 = {20'd0, 10'($urandom), 2'b00};
      else if (sel == 5) r1 = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 6) r1 = {$urandom} | 32'h0000_1000;
      else r1 = $urandom;
      r2 = $urandom;
      if ($urandom_range(0, 3) == 0) tog = ~tog;
      set_r3(($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 8)));
      r3[15:1] = 15'($urandom);
      step();
    end

    // Counter wrap after 65536 back-to-back writes.
    aresetn = 1'b1;
    to_idle();
    tog = r3[0];
    for (int i = 0; i < 65536; i++) begin
      r1 = {20'd0, 10'(i), 2'b00};
      r2 = $urandom;
      tog = ~tog; set_r3(16'd0);
      step();
      if (i == 65534) chk("wr_count max", {16'd0, wr_count}, 32'h0000_FFFF);
    end
    chk("wr_count wrap", {16'd0, wr_count}, 32'd0);
    chk("wrap last we", {31'd0, we}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
